// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Holds one decoded instruction (SKID=0) or up to two (SKID=1) between ID and EXE.
// Handshake: a beat moves on a rising edge when valid and ready are both high
// on that side (accept = in_valid & in_ready, consume = out_valid & out_ready).
// The producer keeps a beat stable until it is accepted. The register keeps its
// outputs stable while out_valid=1 and out_ready=0.
// The FSM state equals the number of held entries and is exported as occupancy.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 5,
   parameter int CMD_W  = 4,
   parameter int BR_W   = 2,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DEST_W-1:0] dest_in,
   input  logic [DATA_W-1:0] reg2_in,
   input  logic [DATA_W-1:0] val1_in,
   input  logic [DATA_W-1:0] val2_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [BR_W-1:0]   br_type_in,
   input  logic [CMD_W-1:0]  exe_cmd_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              wb_en_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DEST_W-1:0] dest,
   output logic [DATA_W-1:0] reg2,
   output logic [DATA_W-1:0] val1,
   output logic [DATA_W-1:0] val2,
   output logic [DATA_W-1:0] pc_out,
   output logic [BR_W-1:0]   br_type_out,
   output logic [CMD_W-1:0]  exe_cmd,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en,
   output logic [1:0]        occupancy
);

   localparam int PW = DEST_W + 4 * DATA_W + BR_W + CMD_W + 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] in_payload, main_q, skid_q;
   logic          accept, consume;
   logic          load_main, load_skid, skid_to_main;
   logic          mem_r_q, mem_w_q, wb_q;

   assign in_payload = {dest_in, reg2_in, val1_in, val2_in, pc_in, br_type_in,
                        exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in};

   assign out_valid = (state_q != EMPTY);
   assign occupancy = state_q;

   // The skid variant derives in_ready from state only so that out_ready never
   // reaches the ID stage combinationally; the single-entry variant passes it through.
   generate
      if (SKID != 0) begin : g_skid_ready
         assign in_ready = (state_q != TWO);
      end else begin : g_single_ready
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   // Next-state and entry-move decode; flush discards everything, including this cycle's beat.
   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d   = ONE;
                  load_main = 1'b1;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  load_main = 1'b1;
               end else if (accept && (SKID != 0)) begin
                  state_d   = TWO;
                  load_skid = 1'b1;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (consume) begin
                  state_d      = ONE;
                  skid_to_main = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // Entry storage; contents survive flush and only change on a load or a skid-to-main move.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)         main_q <= in_payload;
         else if (skid_to_main) main_q <= skid_q;
         if (load_skid)         skid_q <= in_payload;
      end
   end

   assign {dest, reg2, val1, val2, pc_out, br_type_out, exe_cmd,
           mem_r_q, mem_w_q, wb_q} = main_q;

   // An invalid entry must never trigger a memory access or a register write.
   assign mem_r_en = mem_r_q & out_valid;
   assign mem_w_en = mem_w_q & out_valid;
   assign wb_en    = wb_q & out_valid;

endmodule
